ram_rr_arbiter: RTL
===================

// Module: ram_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single RAM port between NREQ requesters
//  (I- and D-side of each CPU, ordered i0,d0,i1,d1).
//  Sits between the cache-side memory controller and the ram block.
//  Replaces fixed priority with rotating fairness, bounded by a per-grant beat limit.
//  Drives ramREN/ramWEN/ramaddr/ramstore and returns per-requester load data and wait.
// PARAMETERS
//  NREQ      4   number of requesters (>=2, power of 2)
//  MAX_BEATS 2   max ACCESS beats per grant before forced rotation (1..15)
// PORTS
//  CLK         in   1          clock, rising edge
//  nRST        in   1          async active-low reset
//  req_ren     in   NREQ       read request per requester
//  req_wen     in   NREQ       write request per requester
//  req_addr    in   NREQ*32    word address per requester (word_t)
//  req_store   in   NREQ*32    write data per requester
//  req_load    out  NREQ*32    read data; ramload to the owner only, others 0
//  req_wait    out  NREQ       1 = stall; 0 for the owner only in an ACCESS cycle
//  ramREN      out  1          ram read enable
//  ramWEN      out  1          ram write enable
//  ramaddr     out  32         ram address
//  ramstore    out  32         ram write data
//  ramload     in   32         ram read data
//  ramstate    in   2          ramstate_t: FREE, BUSY, ACCESS, ERROR
//  grant_valid out  1          an owner holds the port
//  grant_id    out  log2(NREQ) current owner index
// BEHAVIOUR
//  Clock CLK; reset nRST is asynchronous and active-low.
//  - Reset: state=IDLE, last=NREQ-1 (requester 0 wins first), beats=0.
//    Outputs: ramREN=ramWEN=0, ramaddr=ramstore=0, req_wait='1, req_load=0,
//    grant_valid=0, grant_id=0.
//  - req(i) = req_ren[i] | req_wen[i].
//  - FSM states: IDLE, GRANT, RELEASE.
//  - IDLE: if any req(i), owner <= first requester at or after last+1, modulo NREQ.
//    Go to GRANT with beats=0. One cycle arbitration latency.
//  - GRANT: ramaddr=req_addr[owner], ramstore=req_store[owner].
//    If req_wen[owner]: ramWEN=1 and ramREN=0 (write wins if both set).
//    Otherwise ramREN=req_ren[owner].
//  - ramstate==ACCESS in GRANT: req_wait[owner]=0 and req_load[owner]=ramload,
//    same cycle; beats++.
//  - When beats reaches MAX_BEATS on that ACCESS cycle: go to RELEASE, last<=owner.
//  - ramstate BUSY/FREE: hold, all waits 1.
//  - ramstate ERROR: hold GRANT, waits 1, no beat counted.
//  - Owner drops req(owner) in GRANT: abort. Enables deassert that cycle
//    (combinational from req), go to RELEASE, last<=owner. No beat counted.
//  - RELEASE: one dead cycle with all enables 0 and waits 1. Then IDLE.
//    Owner still requesting re-arbitrates behind the others.
//  - New requests arriving during GRANT/RELEASE are only sampled in IDLE.
//  - At most one of ramREN/ramWEN is high; both are 0 outside GRANT.
//  - Reset mid-transfer: immediate return to reset values (async). An in-flight
//    RAM op is dropped; requesters must re-issue.
//  - Worst-case wait for a continuously requesting i is
//    (NREQ-1)*(MAX_BEATS*ram_latency+2) cycles.
// STRUCTURE
//  cpu_types_pkg: word_t, ramstate_t.
//  New package additions: arb_state_t {IDLE,GRANT,RELEASE}; ARB_NREQ=4.
//  Sub-module rr_pick: combinational rotate-priority encoder.
//    Inputs req[NREQ], last; outputs idx, any.
//  Top holds the FSM, owner/last/beats registers, and the output muxes.
// TESTING
//  1. All 4 req_ren=1, ram ACCESS every cycle, MAX_BEATS=2:
//     grants 0,1,2,3,0; each owner sees exactly 2 wait-low cycles.
//  2. Only d0 write, addr 0x40, data 0xDEADBEEF, ramstate BUSY x3 then ACCESS:
//     ramWEN=1, ramaddr=0x40 for 4 cycles; wait[1]=0 only in cycle 4.
//  3. Owner 2 drops req_ren after 1 cycle BUSY:
//     ramREN=0 same cycle, RELEASE, then next grant goes to 3 (not 2).
//  4. Owner asserts req_ren and req_wen together:
//     ramWEN=1, ramREN=0; req_load[owner] is still ramload.
//  5. ramstate=ERROR for 5 cycles, then ACCESS:
//     no beats counted during ERROR, all waits 1; first ACCESS completes beat 1.
//  6. nRST pulsed low mid-GRANT:
//     all outputs at reset values asynchronously; next grant goes to requester 0.

Source files
------------

// File: rtl/ram_rr_arbiter_pkg.sv
// Shared types for the RAM port arbiter: word and ram-state types, arbiter FSM encoding.
// Default sizing lives here so the top and the bench agree on it.
package ram_rr_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  localparam int ARB_NREQ      = 4;
  localparam int ARB_MAX_BEATS = 2;

  typedef logic [1:0] arb_state_t;
  localparam arb_state_t ARB_IDLE    = 2'd0;
  localparam arb_state_t ARB_GRANT   = 2'd1;
  localparam arb_state_t ARB_RELEASE = 2'd2;

endpackage

// File: rtl/ram_rr_arbiter_rr_pick.sv
// Rotate-priority encoder: returns the first requester strictly after last, wrapping,
// so the previous owner is considered last. Purely combinational.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int LW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [LW-1:0]   last_i,
  output logic [LW-1:0]   idx_o,
  output logic            any_o
);

  logic [LW-1:0] cand;

  // Scan from farthest to nearest so the nearest hit after last overwrites the rest;
  // k == NREQ wraps to last itself, the lowest priority.
  always_comb begin
    idx_o = last_i;
    cand  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = last_i + LW'(k);
      if (req_i[cand]) begin
        idx_o = cand;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing the single RAM port between NREQ requesters (i0,d0,i1,d1,...),
// with a per-grant ACCESS beat limit that forces rotation.
module ram_rr_arbiter
  import ram_rr_arbiter_pkg::*;
#(
  parameter int NREQ      = ARB_NREQ,
  parameter int MAX_BEATS = ARB_MAX_BEATS,
  localparam int LW       = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_ren_i,
  input  logic [NREQ-1:0]       req_wen_i,
  input  word_t [NREQ-1:0]      req_addr_i,
  input  word_t [NREQ-1:0]      req_store_i,
  output word_t [NREQ-1:0]      req_load_o,
  output logic [NREQ-1:0]       req_wait_o,
  output logic                  ram_ren_o,
  output logic                  ram_wen_o,
  output word_t                 ram_addr_o,
  output word_t                 ram_store_o,
  input  word_t                 ram_load_i,
  input  ramstate_t             ram_state_i,
  output logic                  grant_valid_o,
  output logic [LW-1:0]         grant_id_o
);

  arb_state_t    state_q, state_d;
  logic [LW-1:0] owner_q, owner_d;
  logic [LW-1:0] last_q, last_d;
  logic [3:0]    beats_q, beats_d;

  logic [LW-1:0] pick_idx;
  logic          pick_any;
  logic          in_grant;
  logic          own_ren, own_wen, own_req;
  logic          beat;
  logic [3:0]    beat_next;
  logic          last_beat;

  rr_pick #(
    .NREQ (NREQ),
    .LW   (LW)
  ) u_pick (
    .req_i  (req_ren_i | req_wen_i),
    .last_i (last_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign in_grant  = (state_q == ARB_GRANT);
  assign own_ren   = req_ren_i[owner_q];
  assign own_wen   = req_wen_i[owner_q];
  assign own_req   = own_ren | own_wen;
  // A beat needs the owner still asking; a dropped request aborts even on ACCESS.
  assign beat      = in_grant & own_req & (ram_state_i == ACCESS);
  assign beat_next = beats_q + 4'd1;
  assign last_beat = (beat_next == 4'(MAX_BEATS));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    beats_d = beats_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          beats_d = 4'd0;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (!own_req) begin
          state_d = ARB_RELEASE;
          last_d  = owner_q;
        end else if (beat) begin
          beats_d = beat_next;
          if (last_beat) begin
            state_d = ARB_RELEASE;
            last_d  = owner_q;
          end
        end
      end
      ARB_RELEASE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      last_q  <= LW'(NREQ - 1);
      beats_q <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beats_q <= beats_d;
    end
  end

  // Enables follow the owner's request combinationally; write wins over read.
  always_comb begin
    ram_wen_o   = in_grant & own_wen;
    ram_ren_o   = in_grant & own_ren & ~own_wen;
    ram_addr_o  = in_grant ? req_addr_i[owner_q]  : '0;
    ram_store_o = in_grant ? req_store_i[owner_q] : '0;
    req_wait_o  = '1;
    req_load_o  = '0;
    if (beat) begin
      req_wait_o[owner_q] = 1'b0;
      req_load_o[owner_q] = ram_load_i;
    end
  end

  assign grant_valid_o = in_grant;
  assign grant_id_o    = owner_q;

endmodule
